// File: rtl/imem_loadable.sv
// imem_loadable: runtime-loadable instruction memory for the fetch stage.
// A program is streamed in over a valid/ready port while in LOAD. In RUN the
// CPU fetches with a one-cycle registered read. A fetch outside
// [BASE_ADDR, BASE_ADDR+loaded_words) returns NOP_WORD and raises addr_fault.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   prog_start               pulse: (re)enter LOAD, restart at word 0
//   prog_valid/data/last     program word stream; prog_last marks final word
//   prog_ready               high while in LOAD
//   prog_overflow            sticky: a word arrived after the memory was full
//   loaded_words             number of valid program words (saturates at DEPTH)
//   fetch_en, address        fetch request and word address
//   out, out_valid           fetched word, valid for a fetch on previous edge
//   addr_fault               previous fetch was out of range
module imem_loadable #(
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             ADDR_WIDTH = 10,
  parameter int unsigned             PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0]     BASE_ADDR  = 16'h31B0,
  parameter logic [DATA_WIDTH-1:0]   NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_start,
  input  logic                  prog_valid,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  prog_last,
  output logic                  prog_ready,
  output logic                  prog_overflow,
  output logic [ADDR_WIDTH:0]   loaded_words,
  input  logic                  fetch_en,
  input  logic [PC_WIDTH-1:0]   address,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid,
  output logic                  addr_fault
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  // Common width for comparing a PC offset against a word count.
  localparam int unsigned CMP_W = (PC_WIDTH > CNT_W) ? PC_WIDTH : CNT_W;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      wr_ptr, wr_ptr_n;
  logic [CNT_W-1:0]      loaded_n;
  logic                  ovf_n;
  logic                  mem_we;
  logic                  out_ld;
  logic                  out_nop;
  logic                  valid_n;
  logic                  fault_n;
  logic                  room;
  logic                  in_range;
  logic [PC_WIDTH-1:0]   offset;
  logic [ADDR_WIDTH-1:0] rd_idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Fetch range check: offset computed at PC width, compared against count.
  assign offset   = address - BASE_ADDR;
  assign rd_idx   = offset[ADDR_WIDTH-1:0];
  assign in_range = (address >= BASE_ADDR) &&
                    (CMP_W'(offset) < CMP_W'(loaded_words));
  // wr_ptr stops at DEPTH, so room means "not yet full".
  assign room     = (wr_ptr != CNT_W'(DEPTH));

  // Next-state, load control and fetch control.
  always_comb begin
    state_n  = state;
    wr_ptr_n = wr_ptr;
    loaded_n = loaded_words;
    ovf_n    = prog_overflow;
    mem_we   = 1'b0;
    out_ld   = 1'b0;
    out_nop  = 1'b0;
    valid_n  = 1'b0;
    fault_n  = 1'b0;

    if (prog_start) begin
      // Restart wins over any beat or fetch in the same cycle.
      state_n  = LOAD;
      wr_ptr_n = '0;
      loaded_n = '0;
      ovf_n    = 1'b0;
      out_ld   = 1'b1;
      out_nop  = 1'b1;
    end else begin
      case (state)
        LOAD: begin
          out_ld  = 1'b1;
          out_nop = 1'b1;
          if (prog_valid) begin
            if (room) begin
              mem_we   = 1'b1;
              wr_ptr_n = wr_ptr + 1'b1;
            end else begin
              ovf_n = 1'b1;
            end
            if (prog_last) begin
              state_n  = RUN;
              loaded_n = wr_ptr_n;
            end
          end
        end
        default: begin
          if (fetch_en) begin
            out_ld  = 1'b1;
            out_nop = !in_range;
            valid_n = 1'b1;
            fault_n = !in_range;
          end
        end
      endcase
    end
  end

  // State, counters and registered fetch outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      wr_ptr        <= '0;
      loaded_words  <= '0;
      prog_overflow <= 1'b0;
      prog_ready    <= 1'b0;
      out           <= '0;
      out_valid     <= 1'b0;
      addr_fault    <= 1'b0;
    end else begin
      state         <= state_n;
      wr_ptr        <= wr_ptr_n;
      loaded_words  <= loaded_n;
      prog_overflow <= ovf_n;
      prog_ready    <= (state_n == LOAD);
      out_valid     <= valid_n;
      addr_fault    <= fault_n;
      if (out_ld) begin
        out <= out_nop ? NOP_WORD : mem[rd_idx];
      end
    end
  end

  // Program store; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= prog_data;
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: a default-size instance plus a 4-word
// instance (ADDR_WIDTH=2) driven by the same stimulus for the overflow case.
module tb_imem_loadable;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_start;
  logic        prog_valid;
  logic [31:0] prog_data;
  logic        prog_last;
  logic        fetch_en;
  logic [15:0] address;

  logic        prog_ready, prog_overflow, out_valid, addr_fault;
  logic [10:0] loaded_words;
  logic [31:0] out;

  logic        s_prog_ready, s_prog_overflow, s_out_valid, s_addr_fault;
  logic [2:0]  s_loaded_words;
  logic [31:0] s_out;

  int checks   = 0;
  int failures = 0;

  logic [31:0] prog [4];

  always #5 clk = ~clk;

  imem_loadable dut (
    .clk(clk), .rst(rst),
    .prog_start(prog_start), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_last(prog_last), .prog_ready(prog_ready), .prog_overflow(prog_overflow),
    .loaded_words(loaded_words), .fetch_en(fetch_en), .address(address),
    .out(out), .out_valid(out_valid), .addr_fault(addr_fault)
  );

  imem_loadable #(.ADDR_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst),
    .prog_start(prog_start), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_last(prog_last), .prog_ready(s_prog_ready), .prog_overflow(s_prog_overflow),
    .loaded_words(s_loaded_words), .fetch_en(fetch_en), .address(address),
    .out(s_out), .out_valid(s_out_valid), .addr_fault(s_addr_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch_check(input logic [15:0] a, input logic [31:0] exp_out,
                             input logic exp_fault, input string tag);
    fetch_en = 1'b1;
    address  = a;
    tick();
    chk({tag, "_out"},   64'(out),        64'(exp_out));
    chk({tag, "_valid"}, 64'(out_valid),  64'd1);
    chk({tag, "_fault"}, 64'(addr_fault), 64'(exp_fault));
    fetch_en = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    prog_valid = 1'b1;
    prog_data  = d;
    prog_last  = last;
    tick();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  initial begin
    prog[0] = 32'h8C0122B0;
    prog[1] = 32'h8C0222B1;
    prog[2] = 32'h8C0322B2;
    prog[3] = 32'h8C0422B3;

    rst = 1'b1; prog_start = 1'b0; prog_valid = 1'b0; prog_data = '0;
    prog_last = 1'b0; fetch_en = 1'b0; address = '0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_out",    64'(out),          64'd0);
    chk("rst_valid",  64'(out_valid),    64'd0);
    chk("rst_fault",  64'(addr_fault),   64'd0);
    chk("rst_ready",  64'(prog_ready),   64'd0);
    chk("rst_loaded", 64'(loaded_words), 64'd0);
    fetch_check(16'h31B0, 32'd0, 1'b1, "rst_fetch");

    // Load four words with a gap beat carrying junk data
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    chk("load_ready_rise", 64'(prog_ready), 64'd1);
    beat(prog[0], 1'b0);
    beat(prog[1], 1'b0);
    prog_data = 32'hDEADBEEF;
    tick();
    chk("gap_ready", 64'(prog_ready), 64'd1);
    chk("gap_out_suppressed", 64'(out), 64'd0);
    beat(prog[2], 1'b0);
    beat(prog[3], 1'b1);
    chk("load_ready_fall", 64'(prog_ready),    64'd0);
    chk("load_count",      64'(loaded_words),  64'd4);
    chk("load_no_ovf",     64'(prog_overflow), 64'd0);

    // Back-to-back fetches
    for (int i = 0; i < 4; i++)
      fetch_check(16'h31B0 + 16'(i), prog[i], 1'b0, $sformatf("fetch%0d", i));

    // Range check
    fetch_check(16'h31B4, 32'd0, 1'b1, "range_hi");
    fetch_check(16'h31AF, 32'd0, 1'b1, "range_lo");

    // Stall: out holds with out_valid low
    fetch_check(16'h31B1, prog[1], 1'b0, "stall_fetch");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_out", i),   64'(out),        64'(prog[1]));
      chk($sformatf("stall%0d_valid", i), 64'(out_valid),  64'd0);
      chk($sformatf("stall%0d_fault", i), 64'(addr_fault), 64'd0);
    end

    // Reset mid-load after two accepted words
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    beat(32'hAAAA0000, 1'b0);
    beat(32'hAAAA0001, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready",  64'(prog_ready),   64'd0);
    chk("midrst_loaded", 64'(loaded_words), 64'd0);
    fetch_check(16'h31B0, 32'd0, 1'b1, "midrst_fetch");

    // prog_start with a data beat: that beat is discarded
    prog_start = 1'b1;
    prog_valid = 1'b1;
    prog_data  = 32'hBBBB0000;
    tick();
    prog_start = 1'b0;
    prog_valid = 1'b0;
    beat(32'hCCCC0000, 1'b1);
    chk("restart_loaded", 64'(loaded_words), 64'd1);
    fetch_check(16'h31B0, 32'hCCCC0000, 1'b0, "restart_w0");
    fetch_check(16'h31B1, 32'd0, 1'b1, "restart_w1");

    // Overflow on the 4-word instance
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    for (int i = 1; i <= 4; i++) beat(32'(i), 1'b0);
    chk("ovf_before",       64'(s_prog_overflow), 64'd0);
    chk("ovf_ready_full",   64'(s_prog_ready),    64'd1);
    beat(32'd5, 1'b1);
    chk("ovf_flag",         64'(s_prog_overflow), 64'd1);
    chk("ovf_loaded",       64'(s_loaded_words),  64'd4);
    chk("ovf_ready_fall",   64'(s_prog_ready),    64'd0);
    chk("big_no_ovf",       64'(prog_overflow),   64'd0);
    chk("big_loaded5",      64'(loaded_words),    64'd5);
    for (int i = 0; i < 4; i++) begin
      fetch_en = 1'b1;
      address  = 16'h31B0 + 16'(i);
      tick();
      chk($sformatf("ovf_fetch%0d", i), 64'(s_out),        64'(i + 1));
      chk($sformatf("ovf_fault%0d", i), 64'(s_addr_fault), 64'd0);
    end
    address = 16'h31B4;
    tick();
    chk("ovf_fetch_beyond_fault", 64'(s_addr_fault), 64'd1);
    chk("ovf_fetch_beyond_out",   64'(s_out),        64'd0);
    chk("big_fetch4",             64'(out),          64'd5);
    fetch_en = 1'b0;
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    chk("ovf_cleared", 64'(s_prog_overflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
